rr_fifo_arbiter_n: RTL and testbench
====================================

# rr_fifo_arbiter_n

Parametrised N-channel round-robin FIFO arbiter: each input channel owns a DEPTH-entry synchronous FIFO, and a work-conserving round-robin scheduler drains the non-empty FIFOs into a single registered output with a valid/ready handshake. It succeeds the fixed 4×8-bit arbiter in the lab datapath. It adds a configurable width, depth and channel count, empty-channel skipping, output back-pressure, and per-channel full/error status.

## Interface
Parameters:
- N_CH, 4, number of input channels (≥2)
- DATA_W, 8, data width in bits
- DEPTH, 8, entries per channel FIFO (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  N_CH  per-channel write request
- din  in  N_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W]
- full  out  N_CH  channel FIFO holds DEPTH entries (registered count)
- wr_err  out  N_CH  one-cycle pulse: write to channel i dropped because full
- dout  out  DATA_W  output word
- dout_ch  out  CH_W  source channel of dout
- valid  out  1  dout/dout_ch hold a word
- ready  in  1  consumer accepts the word this cycle

## Operation
- Write: at a rising edge with wen[i]=1 and full[i]=0, din slice i is pushed into FIFO i.
- Write when full: if wen[i]=1 and full[i]=1, the word is dropped and wr_err[i]=1 for the following cycle. A pop from FIFO i in the same cycle does not rescue the write, because full is evaluated on the count at the start of the cycle.
- Output slot: the slot is free when valid=0 or (valid=1 and ready=1).
- Arbitration: when the slot is free, the arbiter searches channels ptr, ptr+1, … (mod N_CH) for the first non-empty FIFO. Emptiness is taken from the count at the start of the cycle.
- Grant: the granted FIFO is popped at the edge, and its head word loads into dout with dout_ch=grant and valid=1. ptr then becomes (grant+1) mod N_CH.
- No grant: if the slot is free and every FIFO is empty, valid becomes 0. ptr and dout_ch are unchanged.
- Back-pressure: while valid=1 and ready=0, there are no pops and dout, dout_ch and ptr are held stable.
- Simultaneous write and pop on the same channel are allowed; the count is unchanged.
- Wrap-around: read/write indices are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (async, any time): all counts 0, ptr 0, valid 0, dout 0, dout_ch 0, wr_err 0, full 0. FIFO contents are discarded and the memory itself is not cleared.

## Timing
- Minimum write-to-valid latency: a word written at edge t can be popped at edge t+1, so valid is high after edge t+1. There is no bypass path.
- Throughput: one word per cycle with ready held at 1 and at least one non-empty channel.
- full[i] rises after the edge that pushes the DEPTH-th entry.
- wr_err[i] is high for exactly the one cycle after the dropped-write edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package rr_arb_pkg holds the localparams:
  - CH_W = $clog2(N_CH), minimum 1
  - PTR_W = $clog2(DEPTH)
  - CNT_W = PTR_W+1
- Sub-module fifo_sync holds one channel's FIFO: the memory array, read/write indices and count.
  - Ports: clk, rst_n, push, pop, wdata, rdata (combinational head), count, full, empty.
  - Instantiated N_CH times via generate.
- The top level contains the rotating-priority selector, ptr, the output register and the wr_err registers.

## Test plan
- Single word: after reset, ready=1, wen=4'b0001 with din ch0=0x11 for one cycle → valid=1 exactly two edges later with dout=0x11, dout_ch=0; valid=0 the next cycle.
- Fairness: one cycle with wen=4'b1111 and data 0xA0/0xB1/0xC2/0xD3, ready=1 → four consecutive valid cycles with dout_ch 0,1,2,3 and matching data.
- Skip empty: preload ch1 with 0x10,0x11 and ch3 with 0x30,0x31, ready=1 → output order (1,0x10), (3,0x30), (1,0x11), (3,0x31).
- Overflow: ready=0, write 0x00..0x09 to ch2 on ten consecutive edges →
  - dout=0x00 held with valid=1;
  - full[2]=1 after the 0x08 write;
  - 0x09 is dropped and wr_err[2] pulses once;
  - raising ready drains 0x01..0x08 in order.
- Back-pressure: with valid=1, drop ready for three cycles → dout and dout_ch stable and no FIFO counts change; after ready returns, the next grant follows the pre-stall ptr.
- Async reset mid-stream: assert rst_n=0 between edges while valid=1 and all FIFOs partly full → valid, full and wr_err clear immediately without a clock edge; after release, no old data ever appears on dout.

Source files
------------

// File: rtl/rr_fifo_arbiter_n_pkg.sv
// rr_arb_pkg
// Shared sizing helpers for the N-channel round-robin FIFO arbiter.
// The localparams CH_W / PTR_W / CNT_W describe the default build
// (4 channels, 8-deep FIFOs). Modules that take their own N_CH / DEPTH
// parameters derive their widths through the helper functions so every
// file agrees on the same rules.
package rr_arb_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Channel-select width; a 1-bit select is kept even for degenerate sizes.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // FIFO index width; DEPTH is a power of two, so indices wrap naturally.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter needs one extra bit to represent 0..DEPTH.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CH_W  = ch_width(N_CH_DEF);
    localparam int PTR_W = ptr_width(DEPTH_DEF);
    localparam int CNT_W = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/rr_fifo_arbiter_n_if.sv
// rr_fifo_arbiter_n_if
// Bundles the arbiter's write side, status and output handshake.
//   wen/din      : per-channel write requests and packed data
//   full/wr_err  : per-channel status (full level, dropped-write pulse)
//   dout/dout_ch : output word and its source channel
//   valid/ready  : output handshake
// master: producer/consumer side; slave: the arbiter.
interface rr_fifo_arbiter_n_if
    import rr_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = ch_width(N_CH)
) ();

    logic [N_CH-1:0]        wen;
    logic [N_CH*DATA_W-1:0] din;
    logic [N_CH-1:0]        full;
    logic [N_CH-1:0]        wr_err;
    logic [DATA_W-1:0]      dout;
    logic [SEL_W-1:0]       dout_ch;
    logic                   valid;
    logic                   ready;

    modport master (
        output wen, din, ready,
        input  full, wr_err, dout, dout_ch, valid
    );

    modport slave (
        input  wen, din, ready,
        output full, wr_err, dout, dout_ch, valid
    );

endinterface

// File: rtl/rr_fifo_arbiter_n_fifo_sync.sv
// fifo_sync
// One channel's synchronous FIFO: memory array, wrapping read/write
// indices and an occupancy count.
// Ports:
//   clk, rst_n : clock, async active-low reset (indices and count only)
//   push/wdata : write request and data
//   pop/rdata  : read request and combinational head word
//   count      : occupancy 0..DEPTH
//   full/empty : decoded from the registered count
module fifo_sync
    import rr_arb_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = ptr_width(DEPTH),
    localparam int LVL_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LVL_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [LVL_W-1:0]  cnt;
    logic              push_ok;
    logic              pop_ok;

    // Requests are self-guarded so a misbehaving caller cannot corrupt the count.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (cnt == LVL_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_idx];

    // Storage has no reset: a reset only rewinds the indices and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
            if (pop_ok) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + LVL_W'(1);
                2'b01:   cnt <= cnt - LVL_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter_n.sv
// rr_fifo_arbiter_n
// N-channel round-robin FIFO arbiter. Each channel writes into its own
// DEPTH-entry FIFO; a work-conserving rotating-priority selector drains
// non-empty FIFOs into a registered output word with valid/ready.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rr_fifo_arbiter_n_if (wen/din, full/wr_err,
//           dout/dout_ch/valid, ready)
module rr_fifo_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_fifo_arbiter_n_if.slave bus
);

    localparam int SEL_W = ch_width(N_CH);
    localparam int LVL_W = cnt_width(DEPTH);

    logic [N_CH-1:0]   push_vec;
    logic [N_CH-1:0]   pop_vec;
    logic [N_CH-1:0]   full_vec;
    logic [N_CH-1:0]   empty_vec;
    logic [N_CH-1:0]   req;
    logic [DATA_W-1:0] head  [N_CH];
    logic [LVL_W-1:0]  level [N_CH];

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_next;
    logic [SEL_W-1:0]  grant;
    logic              found;
    logic              slot_free;
    logic              take;

    logic [DATA_W-1:0] dout_q;
    logic [SEL_W-1:0]  dout_ch_q;
    logic              valid_q;
    logic [N_CH-1:0]   wr_err_q;

    // Full is the registered level, so a same-cycle pop never rescues a write.
    assign push_vec = bus.wen & ~full_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign req[i]     = (level[i] != '0);
        assign pop_vec[i] = take && (grant == SEL_W'(i)) && !empty_vec[i];

        fifo_sync #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_vec[i]),
            .pop   (pop_vec[i]),
            .wdata (bus.din[i*DATA_W +: DATA_W]),
            .rdata (head[i]),
            .count (level[i]),
            .full  (full_vec[i]),
            .empty (empty_vec[i])
        );
    end

    // Rotating priority: first pass looks at channels ptr..N_CH-1, second pass
    // wraps to 0..ptr-1. Descending loops leave the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                grant = SEL_W'(i);
            end
        end
        if (!found) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    grant = SEL_W'(i);
                end
            end
        end
    end

    assign slot_free = !valid_q || bus.ready;
    assign take      = slot_free && found;
    assign ptr_next  = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);

    // Output slot: load on grant, go idle when nothing is pending, hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            wr_err_q  <= '0;
        end else begin
            wr_err_q <= bus.wen & full_vec;
            if (slot_free) begin
                if (found) begin
                    dout_q    <= head[grant];
                    dout_ch_q <= grant;
                    ptr       <= ptr_next;
                    valid_q   <= 1'b1;
                end else begin
                    valid_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.full    = full_vec;
    assign bus.wr_err  = wr_err_q;
    assign bus.dout    = dout_q;
    assign bus.dout_ch = dout_ch_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_rr_fifo_arbiter_n.sv
// tb_rr_fifo_arbiter_n
// Directed bench for rr_fifo_arbiter_n with N_CH=4, DATA_W=8, DEPTH=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_rr_fifo_arbiter_n;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   assertions = 0;
    int   failures   = 0;

    rr_fifo_arbiter_n_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    rr_fifo_arbiter_n #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        bus.wen   = '0;
        bus.din   = '0;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.wen   = '0;
        bus.din   = '0;
        bus.ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        assertions++;
        if ({bus.valid, bus.dout_ch, bus.dout} !== 11'h000) begin
            failures++;
            $display("[TB] FAIL reset_out: got %h expected %h", {bus.valid, bus.dout_ch, bus.dout}, 11'h000);
        end
        assertions++;
        if (bus.full !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_full: got %b expected %b", bus.full, 4'b0000);
        end
        assertions++;
        if (bus.wr_err !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_wr_err: got %b expected %b", bus.wr_err, 4'b0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_single_word();
        reset_dut();
        bus.ready = 1'b1;
        bus.wen   = 4'b0001;
        bus.din   = 32'h0000_0011;
        step();
        bus.wen = '0;
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_no_bypass: got %b expected %b", bus.valid, 1'b0);
        end
        step();
        assertions++;
        if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd0, 8'h11}) begin
            failures++;
            $display("[TB] FAIL single_word: got %h expected %h", {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd0, 8'h11});
        end
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_drop_valid: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_fairness();
        logic [10:0] exp;
        reset_dut();
        bus.ready = 1'b1;
        bus.wen   = 4'b1111;
        bus.din   = 32'hD3C2_B1A0;
        step();
        bus.wen = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            exp = {1'b1, 2'(k), 8'(8'hA0 + 8'h11 * k)};
            assertions++;
            if ({bus.valid, bus.dout_ch, bus.dout} !== exp) begin
                failures++;
                $display("[TB] FAIL fairness_%0d: got %h expected %h", k, {bus.valid, bus.dout_ch, bus.dout}, exp);
            end
        end
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fairness_idle: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_skip_empty();
        logic [10:0] exp_seq [4];
        exp_seq[0] = {1'b1, 2'd1, 8'h10};
        exp_seq[1] = {1'b1, 2'd3, 8'h30};
        exp_seq[2] = {1'b1, 2'd1, 8'h11};
        exp_seq[3] = {1'b1, 2'd3, 8'h31};
        reset_dut();
        bus.ready = 1'b0;
        bus.wen   = 4'b1010;
        bus.din   = {8'h30, 8'h00, 8'h10, 8'h00};
        step();
        bus.din = {8'h31, 8'h00, 8'h11, 8'h00};
        step();
        bus.wen = '0;
        bus.ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            assertions++;
            if ({bus.valid, bus.dout_ch, bus.dout} !== exp_seq[k]) begin
                failures++;
                $display("[TB] FAIL skip_empty_%0d: got %h expected %h", k, {bus.valid, bus.dout_ch, bus.dout}, exp_seq[k]);
            end
        end
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL skip_empty_idle: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        bus.ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.wen        = 4'b0100;
            bus.din        = '0;
            bus.din[23:16] = 8'(k);
            step();
            if (k == 1) begin
                assertions++;
                if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd2, 8'h00}) begin
                    failures++;
                    $display("[TB] FAIL ovf_first_out: got %h expected %h", {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd2, 8'h00});
                end
            end
            if (k == 7) begin
                assertions++;
                if (bus.full !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL ovf_not_full_yet: got %b expected %b", bus.full, 4'b0000);
                end
            end
            if (k == 8) begin
                assertions++;
                if ({bus.full, bus.wr_err} !== {4'b0100, 4'b0000}) begin
                    failures++;
                    $display("[TB] FAIL ovf_full_rise: got %b expected %b", {bus.full, bus.wr_err}, {4'b0100, 4'b0000});
                end
            end
        end
        bus.wen = '0;
        assertions++;
        if (bus.wr_err !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL ovf_wr_err: got %b expected %b", bus.wr_err, 4'b0100);
        end
        assertions++;
        if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd2, 8'h00}) begin
            failures++;
            $display("[TB] FAIL ovf_hold: got %h expected %h", {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd2, 8'h00});
        end
        step();
        assertions++;
        if ({bus.full, bus.wr_err} !== {4'b0100, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL ovf_err_one_cycle: got %b expected %b", {bus.full, bus.wr_err}, {4'b0100, 4'b0000});
        end
        bus.ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            assertions++;
            if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd2, 8'(k)}) begin
                failures++;
                $display("[TB] FAIL ovf_drain_%0d: got %h expected %h", k, {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd2, 8'(k)});
            end
            if (k == 1) begin
                assertions++;
                if (bus.full !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL ovf_full_fall: got %b expected %b", bus.full, 4'b0000);
                end
            end
        end
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_dropped_word: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_back_pressure();
        logic [10:0] exp;
        int          c;
        int          w;
        reset_dut();
        bus.ready = 1'b0;
        bus.wen   = 4'b1111;
        bus.din   = {8'h40, 8'h30, 8'h20, 8'h10};
        step();
        bus.din = {8'h41, 8'h31, 8'h21, 8'h11};
        step();
        bus.wen = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            assertions++;
            if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd0, 8'h10}) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", k, {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd0, 8'h10});
            end
        end
        bus.ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            c = (k + 1) % 4;
            w = (k < 3) ? 0 : 1;
            exp = {1'b1, 2'(c), 8'(16 * (c + 1) + w)};
            step();
            assertions++;
            if ({bus.valid, bus.dout_ch, bus.dout} !== exp) begin
                failures++;
                $display("[TB] FAIL stall_resume_%0d: got %h expected %h", k, {bus.valid, bus.dout_ch, bus.dout}, exp);
            end
        end
        step();
        assertions++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_drained: got %b expected %b", bus.valid, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        bus.ready = 1'b0;
        bus.wen   = 4'b1111;
        bus.din   = 32'hE3E2_E1E0;
        step();
        bus.wen = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            bus.din = {8'(8'h40 + k), 24'h000000};
            step();
        end
        assertions++;
        if ({bus.valid, bus.full, bus.wr_err} !== {1'b1, 4'b1000, 4'b1000}) begin
            failures++;
            $display("[TB] FAIL areset_setup: got %b expected %b", {bus.valid, bus.full, bus.wr_err}, {1'b1, 4'b1000, 4'b1000});
        end
        #3 rst_n = 1'b0;
        bus.wen = '0;
        #1;
        assertions++;
        if ({bus.valid, bus.full, bus.wr_err} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL areset_immediate: got %b expected %b", {bus.valid, bus.full, bus.wr_err}, 9'b0);
        end
        assertions++;
        if ({bus.dout_ch, bus.dout} !== 10'h000) begin
            failures++;
            $display("[TB] FAIL areset_dout: got %h expected %h", {bus.dout_ch, bus.dout}, 10'h000);
        end
        #1 rst_n = 1'b1;
        bus.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            assertions++;
            if (bus.valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL areset_stale_%0d: got %b expected %b", k, bus.valid, 1'b0);
            end
        end
        bus.wen = 4'b0100;
        bus.din = 32'h0077_0000;
        step();
        bus.wen = '0;
        step();
        assertions++;
        if ({bus.valid, bus.dout_ch, bus.dout} !== {1'b1, 2'd2, 8'h77}) begin
            failures++;
            $display("[TB] FAIL areset_fresh: got %h expected %h", {bus.valid, bus.dout_ch, bus.dout}, {1'b1, 2'd2, 8'h77});
        end
    endtask

    initial begin
        bus.wen   = '0;
        bus.din   = '0;
        bus.ready = 1'b0;
        test_reset();
        test_single_word();
        test_fairness();
        test_skip_empty();
        test_overflow();
        test_back_pressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
